// File: rtl/sr_flag_arbiter_if.sv
// Request/grant bus between flag requesters and the SR flag arbiter,
// plus the flag bank state the arbiter exposes.
interface sr_flag_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      req_ready;
    logic [NFLAG-1:0]     flag_q;
    logic [NFLAG-1:0]     flag_qbar;
    logic                 busy;
    logic [7:0]           conflict_cnt;

    modport master (
        output req_valid,
        output req_op,
        output req_idx,
        input  req_ready,
        input  flag_q,
        input  flag_qbar,
        input  busy,
        input  conflict_cnt
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_idx,
        output req_ready,
        output flag_q,
        output flag_qbar,
        output busy,
        output conflict_cnt
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising set/clear requests into one SR flag bank:
// one grant per cycle, applied to the bank on the following edge.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input logic              clk,
    input logic              rst,
    sr_flag_arbiter_if.slave bus
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTRW-1:0] LAST_REQ = PTRW'(NREQ - 1);

    logic [IDXW-1:0]  req_idx_arr [NREQ];
    logic [NREQ-1:0]  req_in_range;
    logic [NREQ-1:0]  eligible;

    logic             grant_valid;
    logic [PTRW-1:0]  grant_sel;
    logic [NREQ-1:0]  grant_onehot;
    logic             conflict;

    logic [PTRW-1:0]  ptr_reg;
    logic [PTRW-1:0]  ptr_next;
    logic [NREQ-1:0]  req_ready_reg;
    logic             apply_valid_reg;
    logic             apply_op_reg;
    logic [IDXW-1:0]  apply_idx_reg;
    logic [7:0]       conflict_cnt_reg;
    logic [7:0]       conflict_cnt_next;

    logic [NFLAG-1:0] flag_we;
    logic [NFLAG-1:0] flag_q_reg;
    logic [NFLAG-1:0] flag_qbar_reg;

    // A requester holding its grant this cycle is excluded so the same
    // request cannot be accepted twice.
    assign eligible = bus.req_valid & ~req_ready_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_idx_arr[gi]  = bus.req_idx[gi*IDXW +: IDXW];
            assign req_in_range[gi] = ({{(32-IDXW){1'b0}}, req_idx_arr[gi]} < 32'(NFLAG));
        end
    endgenerate

    always_comb begin
        int cand;
        cand         = 0;
        grant_valid  = 1'b0;
        grant_sel    = '0;
        grant_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_reg) + k) % NREQ;
            if (!grant_valid && eligible[cand]) begin
                grant_valid        = 1'b1;
                grant_sel          = PTRW'(cand);
                grant_onehot[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            ptr_next = (grant_sel == LAST_REQ) ? '0 : grant_sel + PTRW'(1);
        end
    end

    // Opposite ops on the same in-range flag among eligible requesters;
    // purely observational, the round-robin winner still goes through.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (eligible[i] && eligible[j] && req_in_range[i] &&
                    (req_idx_arr[i] == req_idx_arr[j]) &&
                    (bus.req_op[i] != bus.req_op[j])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_comb begin
        conflict_cnt_next = conflict_cnt_reg;
        if (conflict && (conflict_cnt_reg != 8'hFF)) begin
            conflict_cnt_next = conflict_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg          <= '0;
            req_ready_reg    <= '0;
            apply_valid_reg  <= 1'b0;
            apply_op_reg     <= 1'b0;
            apply_idx_reg    <= '0;
            conflict_cnt_reg <= '0;
        end else begin
            ptr_reg          <= ptr_next;
            req_ready_reg    <= grant_onehot;
            apply_valid_reg  <= grant_valid;
            conflict_cnt_reg <= conflict_cnt_next;
            if (grant_valid) begin
                apply_op_reg  <= bus.req_op[grant_sel];
                apply_idx_reg <= req_idx_arr[grant_sel];
            end
        end
    end

    // Out-of-range indices decode to no write enable, so they are dropped here.
    generate
        for (gi = 0; gi < NFLAG; gi++) begin : g_flag
            assign flag_we[gi] = apply_valid_reg && (apply_idx_reg == IDXW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q_reg    <= '0;
            flag_qbar_reg <= '1;
        end else begin
            flag_q_reg    <= (flag_q_reg    & ~flag_we) | (flag_we & {NFLAG{apply_op_reg}});
            flag_qbar_reg <= (flag_qbar_reg & ~flag_we) | (flag_we & {NFLAG{~apply_op_reg}});
        end
    end

    assign bus.req_ready    = req_ready_reg;
    assign bus.flag_q       = flag_q_reg;
    assign bus.flag_qbar    = flag_qbar_reg;
    assign bus.busy         = apply_valid_reg;
    assign bus.conflict_cnt = conflict_cnt_reg;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: an 8-flag instance for the main
// behaviour and a 6-flag instance for out-of-range indices.
module tb_sr_flag_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(4), .NFLAG(8), .IDXW(3)) bus8 ();
    sr_flag_arbiter_if #(.NREQ(4), .NFLAG(6), .IDXW(3)) bus6 ();

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive8(input logic [3:0] v, input logic [3:0] op, input logic [11:0] idx);
        bus8.req_valid = v;
        bus8.req_op    = op;
        bus8.req_idx   = idx;
    endtask

    task automatic drive6(input logic [3:0] v, input logic [3:0] op, input logic [11:0] idx);
        bus6.req_valid = v;
        bus6.req_op    = op;
        bus6.req_idx   = idx;
    endtask

    initial begin
        logic [7:0] exp_flags;
        drive8(4'b0, 4'b0, 12'd0);
        drive6(4'b0, 4'b0, 12'd0);

        // Reset state
        cyc(2);
        check("rst_flag_q",    32'(bus8.flag_q),       32'h00);
        check("rst_flag_qbar", 32'(bus8.flag_qbar),    32'hFF);
        check("rst_ready",     32'(bus8.req_ready),    32'h0);
        check("rst_busy",      32'(bus8.busy),         32'h0);
        check("rst_cnt",       32'(bus8.conflict_cnt), 32'h0);
        rst = 1'b0;

        // Single request: requester 2 sets then clears idx 5
        drive8(4'b0100, 4'b0100, {3'd0, 3'd5, 3'd0, 3'd0});
        cyc(1);
        $display("txn single_set req2 idx5 ready=%b", bus8.req_ready);
        check("single_ready", 32'(bus8.req_ready), 32'b0100);
        check("single_busy",  32'(bus8.busy),      32'h1);
        check("single_q_pre", 32'(bus8.flag_q),    32'h00);
        drive8(4'b0, 4'b0, 12'd0);
        cyc(1);
        check("single_q_set",    32'(bus8.flag_q),    32'h20);
        check("single_qbar_set", 32'(bus8.flag_qbar), 32'hDF);
        check("single_idle",     32'(bus8.busy),      32'h0);
        drive8(4'b0100, 4'b0000, {3'd0, 3'd5, 3'd0, 3'd0});
        cyc(1);
        $display("txn single_clr req2 idx5 ready=%b", bus8.req_ready);
        check("clr_ready", 32'(bus8.req_ready), 32'b0100);
        drive8(4'b0, 4'b0, 12'd0);
        cyc(1);
        check("clr_q",    32'(bus8.flag_q),    32'h00);
        check("clr_qbar", 32'(bus8.flag_qbar), 32'hFF);

        // Pointer wrap: requester 3 alone, then 0 and 1 together (ptr must be 0)
        drive8(4'b1000, 4'b1000, {3'd6, 3'd0, 3'd0, 3'd0});
        cyc(1);
        $display("txn wrap req3 idx6 ready=%b", bus8.req_ready);
        check("wrap_ready3", 32'(bus8.req_ready), 32'b1000);
        drive8(4'b0011, 4'b0011, {3'd0, 3'd0, 3'd4, 3'd7});
        cyc(1);
        $display("txn wrap req0 idx7 ready=%b", bus8.req_ready);
        check("wrap_ready0", 32'(bus8.req_ready), 32'b0001);
        check("wrap_q6",     32'(bus8.flag_q),    32'h40);
        drive8(4'b0010, 4'b0010, {3'd0, 3'd0, 3'd4, 3'd0});
        cyc(1);
        check("wrap_ready1", 32'(bus8.req_ready), 32'b0010);
        check("wrap_q67",    32'(bus8.flag_q),    32'hC0);
        drive8(4'b0, 4'b0, 12'd0);
        cyc(1);
        check("wrap_q_all", 32'(bus8.flag_q),    32'hD0);
        check("wrap_idle",  32'(bus8.req_ready), 32'h0);

        // Reset with a grant in flight
        drive8(4'b0010, 4'b0010, {3'd0, 3'd0, 3'd1, 3'd0});
        cyc(1);
        check("inflight_ready", 32'(bus8.req_ready), 32'b0010);
        check("inflight_busy",  32'(bus8.busy),      32'h1);
        rst = 1'b1;
        drive8(4'b0, 4'b0, 12'd0);
        #1;
        $display("txn mid_reset asserted");
        check("mrst_flag_q",    32'(bus8.flag_q),       32'h00);
        check("mrst_flag_qbar", 32'(bus8.flag_qbar),    32'hFF);
        check("mrst_ready",     32'(bus8.req_ready),    32'h0);
        check("mrst_busy",      32'(bus8.busy),         32'h0);
        check("mrst_cnt",       32'(bus8.conflict_cnt), 32'h0);
        cyc(1);
        rst = 1'b0;
        cyc(2);
        check("mrst_no_ghost", 32'(bus8.flag_q), 32'h00);
        check("mrst_idle",     32'(bus8.busy),   32'h0);

        // Round-robin: all four set their own index continuously
        drive8(4'b1111, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0});
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            exp_flags = (k >= 2) ? 8'((1 << ((k - 1 < 4) ? k - 1 : 4)) - 1) : 8'h00;
            $display("txn rr cycle %0d ready=%b flag_q=%h", k, bus8.req_ready, bus8.flag_q);
            check("rr_ready", 32'(bus8.req_ready), 32'(1 << ((k - 1) % 4)));
            check("rr_flag_q", 32'(bus8.flag_q), 32'(exp_flags));
        end
        drive8(4'b0, 4'b0, 12'd0);
        cyc(1);
        check("rr_done_q",   32'(bus8.flag_q),       32'h0F);
        check("rr_done_cnt", 32'(bus8.conflict_cnt), 32'h0);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;

        // Conflict: requester 0 sets idx 3, requester 1 clears idx 3
        drive8(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd3, 3'd3});
        cyc(1);
        $display("txn conflict req0 set/req1 clr idx3 ready=%b cnt=%0d", bus8.req_ready, bus8.conflict_cnt);
        check("cf_ready0", 32'(bus8.req_ready),    32'b0001);
        check("cf_cnt",    32'(bus8.conflict_cnt), 32'd1);
        check("cf_q_pre",  32'(bus8.flag_q),       32'h00);
        drive8(4'b0010, 4'b0000, {3'd0, 3'd0, 3'd3, 3'd0});
        cyc(1);
        check("cf_ready1", 32'(bus8.req_ready),    32'b0010);
        check("cf_q_set",  32'(bus8.flag_q),       32'h08);
        check("cf_qb_set", 32'(bus8.flag_qbar),    32'hF7);
        check("cf_cnt_1",  32'(bus8.conflict_cnt), 32'd1);
        drive8(4'b0, 4'b0, 12'd0);
        cyc(1);
        check("cf_q_clr",  32'(bus8.flag_q),    32'h00);
        check("cf_qb_clr", 32'(bus8.flag_qbar), 32'hFF);

        // Saturation: four requesters keep opposing ops on idx 2
        drive8(4'b1111, 4'b0101, {3'd2, 3'd2, 3'd2, 3'd2});
        for (int k = 1; k <= 300; k++) begin
            cyc(1);
            if (k == 100) begin
                $display("txn saturate cycle 100 cnt=%0d", bus8.conflict_cnt);
                check("sat_cnt_100", 32'(bus8.conflict_cnt), 32'd101);
            end
            if (k == 254) check("sat_cnt_254", 32'(bus8.conflict_cnt), 32'd255);
        end
        check("sat_cnt_300", 32'(bus8.conflict_cnt), 32'd255);
        cyc(5);
        $display("txn saturate hold cnt=%0d", bus8.conflict_cnt);
        check("sat_cnt_hold", 32'(bus8.conflict_cnt), 32'd255);
        drive8(4'b0, 4'b0, 12'd0);

        // Out-of-range index on the 6-flag instance
        drive6(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd7});
        cyc(1);
        $display("txn oor req0 idx7 ready=%b", bus6.req_ready);
        check("oor_ready", 32'(bus6.req_ready), 32'b0001);
        drive6(4'b0, 4'b0, 12'd0);
        cyc(1);
        check("oor_q",    32'(bus6.flag_q),    32'h00);
        check("oor_qbar", 32'(bus6.flag_qbar), 32'h3F);
        check("oor_busy", 32'(bus6.busy),      32'h0);
        drive6(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd7, 3'd7});
        cyc(1);
        check("oor_cf_ready", 32'(bus6.req_ready),    32'b0010);
        check("oor_cf_cnt",   32'(bus6.conflict_cnt), 32'd0);
        drive6(4'b0, 4'b0, 12'd0);
        cyc(1);
        drive6(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5});
        cyc(1);
        check("inr_ready", 32'(bus6.req_ready), 32'b0001);
        drive6(4'b0, 4'b0, 12'd0);
        cyc(1);
        $display("txn in-range req0 idx5 flag_q=%h", bus6.flag_q);
        check("inr_q",    32'(bus6.flag_q),    32'h20);
        check("inr_qbar", 32'(bus6.flag_qbar), 32'h1F);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
